// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: frame-atomic round-robin arbiter in front of a UART TX byte port.
// A grant is held from the first byte of a frame through its last-flagged byte.
// A watchdog drops an owner that stops supplying bytes mid-frame.
// A one-byte output register decouples the sources from the UART backpressure.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 4096,
  parameter int TIMEOUT_W   = 16
) (
  input  logic                   I_clk,
  input  logic                   I_rst_n,
  input  logic [NUM_REQ-1:0]     I_req_valid,
  input  logic [8*NUM_REQ-1:0]   I_req_data,
  input  logic [NUM_REQ-1:0]     I_req_last,
  output logic [NUM_REQ-1:0]     O_req_ready,
  output logic                   O_tx_data_valid,
  output logic [7:0]             O_tx_data,
  input  logic                   I_tx_data_ready,
  output logic [NUM_REQ-1:0]     O_grant,
  output logic                   O_busy,
  output logic                   O_frame_done,
  output logic                   O_timeout_err,
  output logic [2:0]             O_err_src
);

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  localparam logic [2:0]           LAST_IDX = 3'(NUM_REQ - 1);
  localparam logic [TIMEOUT_W-1:0] WD_LIM   = TIMEOUT_W'(TIMEOUT_CYC - 1);
  localparam bit                   WD_EN    = (TIMEOUT_CYC != 0);

  state_t                r_state, w_state_nxt;
  logic [NUM_REQ-1:0]    r_grant, w_grant_nxt;
  logic [2:0]            r_owner, w_owner_nxt;
  logic [2:0]            r_rr, w_rr_nxt;
  logic [TIMEOUT_W-1:0]  r_wd, w_wd_nxt;
  logic                  r_frame_done, w_frame_done_nxt;
  logic                  r_timeout_err, w_timeout_err_nxt;
  logic [2:0]            r_err_src, w_err_src_nxt;
  logic                  r_tx_valid;
  logic [7:0]            r_tx_data;

  logic                  w_out_free;
  logic                  w_acc;
  logic                  w_own_valid;
  logic                  w_own_last;
  logic                  w_starve;
  logic [7:0]            w_acc_data;
  logic                  w_pick_vld;
  logic [2:0]            w_pick_idx;
  logic [NUM_REQ-1:0]    w_pick_vec;
  logic [2:0]            w_rr_adv;

  // Ready depends only on grant and output-register occupancy, never on valid.
  assign w_out_free  = ~r_tx_valid | I_tx_data_ready;
  assign O_req_ready = r_grant & {NUM_REQ{w_out_free}};
  assign w_acc       = |(I_req_valid & O_req_ready);
  assign w_own_valid = |(I_req_valid & r_grant);
  assign w_own_last  = |(I_req_last & r_grant);
  // Starvation only while the owner could have sent; output stalls do not count.
  assign w_starve    = (|O_req_ready) & ~w_own_valid;
  assign w_rr_adv    = (r_owner == LAST_IDX) ? 3'd0 : r_owner + 3'd1;

  // Owner byte mux (grant is one-hot or zero).
  always_comb begin
    w_acc_data = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (r_grant[k]) w_acc_data = I_req_data[8*k +: 8];
  end

  // Round-robin pick: first requester at/after the pointer, then wrap to the lowest index.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    w_pick_vec = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_pick_vld && I_req_valid[k] && (3'(k) >= r_rr)) begin
        w_pick_vld    = 1'b1;
        w_pick_idx    = 3'(k);
        w_pick_vec[k] = 1'b1;
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_pick_vld && I_req_valid[k]) begin
        w_pick_vld    = 1'b1;
        w_pick_idx    = 3'(k);
        w_pick_vec[k] = 1'b1;
      end
    end
  end

  // Next-state: grant on request, release on last byte or on watchdog expiry.
  always_comb begin
    w_state_nxt       = r_state;
    w_grant_nxt       = r_grant;
    w_owner_nxt       = r_owner;
    w_rr_nxt          = r_rr;
    w_wd_nxt          = r_wd;
    w_frame_done_nxt  = 1'b0;
    w_timeout_err_nxt = 1'b0;
    w_err_src_nxt     = r_err_src;
    case (r_state)
      S_IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt = S_GRANT;
          w_owner_nxt = w_pick_idx;
          w_grant_nxt = w_pick_vec;
          w_wd_nxt    = '0;
        end
      end
      S_GRANT: begin
        if (w_acc) begin
          // An accepted byte always beats the watchdog threshold.
          w_wd_nxt = '0;
          if (w_own_last) begin
            w_frame_done_nxt = 1'b1;
            w_grant_nxt      = '0;
            w_rr_nxt         = w_rr_adv;
            w_state_nxt      = S_IDLE;
          end
        end else if (w_starve) begin
          if (WD_EN && (r_wd == WD_LIM)) begin
            w_timeout_err_nxt = 1'b1;
            w_err_src_nxt     = r_owner;
            w_grant_nxt       = '0;
            w_rr_nxt          = w_rr_adv;
            w_wd_nxt          = '0;
            w_state_nxt       = S_IDLE;
          end else begin
            w_wd_nxt = r_wd + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // Arbiter state register.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_owner       <= '0;
      r_rr          <= '0;
      r_wd          <= '0;
      r_frame_done  <= 1'b0;
      r_timeout_err <= 1'b0;
      r_err_src     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_owner       <= w_owner_nxt;
      r_rr          <= w_rr_nxt;
      r_wd          <= w_wd_nxt;
      r_frame_done  <= w_frame_done_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_err_src     <= w_err_src_nxt;
    end
  end

  // Output byte register: load on accept, empty on consume; drains after release too.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else if (w_acc) begin
      r_tx_valid <= 1'b1;
      r_tx_data  <= w_acc_data;
    end else if (I_tx_data_ready) begin
      r_tx_valid <= 1'b0;
    end
  end

  assign O_grant         = r_grant;
  assign O_busy          = (r_state == S_GRANT);
  assign O_tx_data_valid = r_tx_valid;
  assign O_tx_data       = r_tx_data;
  assign O_frame_done    = r_frame_done;
  assign O_timeout_err   = r_timeout_err;
  assign O_err_src       = r_err_src;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: constant vector table, directed multi-cycle sequences,
// and randomized traffic compared cycle by cycle against a queue/integer reference model.
module tb_uart_tx_arbiter;
  localparam int N  = 2;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_last, req_ready;
  logic [15:0] req_data;
  logic        txv, txr;
  logic [7:0]  txd;
  logic [1:0]  grant;
  logic        busy, fdone, toerr;
  logic [2:0]  esrc;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO), .TIMEOUT_W(16)) dut (
    .I_clk(clk), .I_rst_n(rst_n),
    .I_req_valid(req_valid), .I_req_data(req_data), .I_req_last(req_last),
    .O_req_ready(req_ready),
    .O_tx_data_valid(txv), .O_tx_data(txd), .I_tx_data_ready(txr),
    .O_grant(grant), .O_busy(busy), .O_frame_done(fdone),
    .O_timeout_err(toerr), .O_err_src(esrc)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc_no = 0;

  // sampled DUT outputs of the current cycle
  logic [1:0] s_grant, s_ready;
  logic       s_txv, s_fd, s_to, s_busy;
  logic [7:0] s_txd;
  logic [2:0] s_es;

  // reference model: owner index (-1 idle), rr pointer, starvation count, output buffer
  int         m_owner, m_rr, m_wd, m_es;
  bit         m_ov, m_fd, m_to;
  logic [7:0] m_od;

  // sources: {last, byte}
  logic [8:0] sq0[$], sq1[$];
  logic [1:0] last_v;

  // observations
  logic [7:0] q_out[$];
  int         consume_cyc[$], grant_order[$];
  int         fd_cnt, to_cnt, es_at_to;
  logic [1:0] prev_grant;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_rr = 0; m_wd = 0; m_es = 0;
    m_ov = 0; m_fd = 0; m_to = 0; m_od = 8'h00;
    prev_grant = 2'b00;
  endtask

  task automatic clr_obs();
    q_out.delete(); consume_cyc.delete(); grant_order.delete();
    fd_cnt = 0; to_cnt = 0; es_at_to = -1;
  endtask

  // Advance the model by one clock using the cycle's inputs.
  task automatic model_step(input logic [1:0] v, input logic [15:0] d,
                            input logic [1:0] l, input logic tr);
    int  o;
    bit  free, acc, ov_o, lst_o, found;
    logic [7:0] dat_o;
    o     = m_owner;
    free  = !m_ov || tr;
    ov_o  = (o == 1) ? v[1] : v[0];
    lst_o = (o == 1) ? l[1] : l[0];
    dat_o = (o == 1) ? d[15:8] : d[7:0];
    acc   = (o >= 0) && free && ov_o;
    m_fd = 0; m_to = 0;
    if (acc) begin m_ov = 1; m_od = dat_o; end
    else if (tr) m_ov = 0;
    if (o < 0) begin
      found = 0;
      for (int i = 0; i < N; i++) begin
        int c;
        c = (m_rr + i) % N;
        if (!found && (((v >> c) & 2'b01) != 2'b00)) begin
          found = 1; m_owner = c; m_wd = 0;
        end
      end
    end else if (acc) begin
      m_wd = 0;
      if (lst_o) begin m_fd = 1; m_rr = (o + 1) % N; m_owner = -1; end
    end else if (free) begin
      m_wd++;
      if (m_wd == TO) begin
        m_to = 1; m_es = o; m_rr = (o + 1) % N; m_owner = -1; m_wd = 0;
      end
    end
  endtask

  // One clock: drive, sample on the falling edge, compare with the model, step the model.
  task automatic cyc(input logic [1:0] v, input logic [15:0] d,
                     input logic [1:0] l, input logic tr);
    logic [1:0] e_grant, e_ready;
    req_valid = v; req_data = d; req_last = l; txr = tr;
    @(negedge clk);
    s_grant = grant; s_ready = req_ready; s_txv = txv; s_txd = txd;
    s_fd = fdone; s_to = toerr; s_es = esrc; s_busy = busy;
    e_grant = (m_owner >= 0) ? (2'b01 << m_owner) : 2'b00;
    e_ready = (m_owner >= 0 && (!m_ov || tr)) ? (2'b01 << m_owner) : 2'b00;
    chk($sformatf("grant@%0d", cyc_no), s_grant, e_grant);
    chk($sformatf("ready@%0d", cyc_no), s_ready, e_ready);
    chk($sformatf("busy@%0d", cyc_no), s_busy, (m_owner >= 0));
    chk($sformatf("txv@%0d", cyc_no), s_txv, m_ov);
    chk($sformatf("txd@%0d", cyc_no), s_txd, m_od);
    chk($sformatf("fdone@%0d", cyc_no), s_fd, m_fd);
    chk($sformatf("tmo@%0d", cyc_no), s_to, m_to);
    chk($sformatf("esrc@%0d", cyc_no), s_es, m_es);
    if (s_txv && tr) begin q_out.push_back(s_txd); consume_cyc.push_back(cyc_no); end
    if (s_fd) fd_cnt++;
    if (s_to) begin to_cnt++; es_at_to = int'(s_es); end
    if (prev_grant == 2'b00 && s_grant != 2'b00) grant_order.push_back(s_grant[1] ? 1 : 0);
    prev_grant = s_grant;
    model_step(v, d, l, tr);
    cyc_no++;
    @(posedge clk); #1;
  endtask

  task automatic run_cycle(input logic [1:0] want, input logic tr);
    logic [1:0] v, l;
    logic [15:0] d;
    v = '0; l = '0; d = '0;
    if (want[0] && sq0.size() > 0) begin v[0] = 1'b1; d[7:0]  = sq0[0][7:0]; l[0] = sq0[0][8]; end
    if (want[1] && sq1.size() > 0) begin v[1] = 1'b1; d[15:8] = sq1[0][7:0]; l[1] = sq1[0][8]; end
    last_v = v;
    cyc(v, d, l, tr);
    if (v[0] && s_ready[0]) void'(sq0.pop_front());
    if (v[1] && s_ready[1]) void'(sq1.pop_front());
  endtask

  task automatic drain(input logic [1:0] want, input logic tr);
    for (int i = 0; i < 60 && (sq0.size() + sq1.size() > 0); i++) run_cycle(want, tr);
    chk("queues_drained", sq0.size() + sq1.size(), 0);
    for (int i = 0; i < 3; i++) run_cycle(2'b00, 1'b1);
  endtask

  task automatic chk_stream(input string nm, input logic [7:0] e[$]);
    chk({nm, "_len"}, q_out.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      if (i < q_out.size()) chk($sformatf("%s_b%0d", nm, i), q_out[i], e[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0; txr = 1'b1;
    model_reset(); sq0.delete(); sq1.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic       v0; logic [7:0] d0; logic l0; logic tr;
    logic [1:0] e_grant; logic [1:0] e_ready; logic e_txv; logic [7:0] e_txd; logic e_fd;
  } vec_t;
  vec_t tbl[6];

  initial begin
    logic [7:0] e[$];
    int starve, bad_rdy;
    logic trv;

    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 8'hA5, 1'b0, 1'b1, 2'b01, 2'b01, 1'b0, 8'h00, 1'b0};
    tbl[2] = '{1'b1, 8'h01, 1'b0, 1'b1, 2'b01, 2'b01, 1'b1, 8'hA5, 1'b0};
    tbl[3] = '{1'b1, 8'h02, 1'b1, 1'b1, 2'b01, 2'b01, 1'b1, 8'h01, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 8'h02, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 8'h02, 1'b0};

    // reset state
    rst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0; txr = 1'b1;
    model_reset(); clr_obs();
    #12;
    chk("rst_grant", grant, 0); chk("rst_busy", busy, 0); chk("rst_txv", txv, 0);
    chk("rst_txd", txd, 0); chk("rst_fd", fdone, 0); chk("rst_to", toerr, 0);
    chk("rst_es", esrc, 0); chk("rst_ready", req_ready, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // single source 3-byte frame, constant vector table
    for (int i = 0; i < 6; i++) begin
      cyc({1'b0, tbl[i].v0}, {8'h00, tbl[i].d0}, {1'b0, tbl[i].l0}, tbl[i].tr);
      chk($sformatf("t1_grant%0d", i), s_grant, tbl[i].e_grant);
      chk($sformatf("t1_ready%0d", i), s_ready, tbl[i].e_ready);
      chk($sformatf("t1_txv%0d", i), s_txv, tbl[i].e_txv);
      chk($sformatf("t1_txd%0d", i), s_txd, tbl[i].e_txd);
      chk($sformatf("t1_fd%0d", i), s_fd, tbl[i].e_fd);
    end

    // round-robin between two continuous requesters
    do_reset(); clr_obs();
    sq0 = '{9'h010, 9'h011, 9'h112, 9'h013, 9'h014, 9'h115};
    sq1 = '{9'h020, 9'h021, 9'h122, 9'h023, 9'h024, 9'h125};
    drain(2'b11, 1'b1);
    e = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'h13, 8'h14, 8'h15, 8'h23, 8'h24, 8'h25};
    chk_stream("t2", e);
    chk("t2_ngrants", grant_order.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < grant_order.size()) chk($sformatf("t2_order%0d", i), grant_order[i], i % 2);
    chk("t2_fdcnt", fd_cnt, 4);

    // backpressure: tx_ready alternates during a 4-byte frame
    clr_obs(); bad_rdy = 0;
    sq0 = '{9'h030, 9'h031, 9'h032, 9'h133};
    for (int i = 0; i < 40 && sq0.size() > 0; i++) begin
      trv = (i % 2 == 0);
      run_cycle(2'b01, trv);
      if (s_txv && !trv && s_ready != 2'b00) bad_rdy++;
    end
    for (int i = 0; i < 3; i++) run_cycle(2'b00, 1'b1);
    e = '{8'h30, 8'h31, 8'h32, 8'h33};
    chk_stream("t3", e);
    chk("t3_ready_when_full", bad_rdy, 0);
    chk("t3_no_timeout", to_cnt, 0);

    // watchdog: src1 stops mid-frame, src0 waits with a frame
    clr_obs(); starve = 0;
    sq1 = '{9'h040, 9'h041};
    sq0 = '{9'h050, 9'h151};
    for (int i = 0; i < 60 && (sq0.size() + sq1.size() > 0); i++) begin
      run_cycle(2'b11, 1'b1);
      if (s_grant == 2'b10 && s_ready[1] && !last_v[1]) starve++;
    end
    for (int i = 0; i < 3; i++) run_cycle(2'b00, 1'b1);
    chk("t4_tocnt", to_cnt, 1);
    chk("t4_esrc", es_at_to, 1);
    chk("t4_starve", starve, TO);
    chk("t4_ngrants", grant_order.size(), 2);
    if (grant_order.size() == 2) begin
      chk("t4_first", grant_order[0], 1);
      chk("t4_next", grant_order[1], 0);
    end
    e = '{8'h40, 8'h41, 8'h50, 8'h51};
    chk_stream("t4", e);

    // reset during the second byte of a frame
    clr_obs();
    sq0 = '{9'h060, 9'h061, 9'h162};
    run_cycle(2'b01, 1'b1);
    run_cycle(2'b01, 1'b1);
    req_valid = 2'b01; req_data = 16'h0061; req_last = 2'b00; txr = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_grant", grant, 0); chk("t5_busy", busy, 0); chk("t5_txv", txv, 0);
    chk("t5_txd", txd, 0); chk("t5_ready", req_ready, 0); chk("t5_fd", fdone, 0);
    chk("t5_to", toerr, 0); chk("t5_es", esrc, 0);
    model_reset(); sq0.delete(); sq1.delete();
    req_valid = '0; req_data = '0;
    @(posedge clk); #1;
    chk("t5_hold_grant", grant, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    clr_obs();
    sq1 = '{9'h070, 9'h171};
    drain(2'b11, 1'b1);
    chk("t5_ngrants", grant_order.size(), 1);
    if (grant_order.size() == 1) chk("t5_first", grant_order[0], 1);
    e = '{8'h70, 8'h71};
    chk_stream("t5", e);

    // back-to-back single-byte frames from src0
    clr_obs();
    sq0 = '{9'h180, 9'h181, 9'h182};
    drain(2'b01, 1'b1);
    e = '{8'h80, 8'h81, 8'h82};
    chk_stream("t6", e);
    chk("t6_fdcnt", fd_cnt, 3);
    for (int i = 1; i < consume_cyc.size(); i++)
      chk($sformatf("t6_gap%0d", i), consume_cyc[i] - consume_cyc[i-1], 2);

    // randomized traffic with idle phases that provoke the watchdog
    do_reset(); clr_obs();
    for (int i = 0; i < 800; i++) begin
      logic [1:0] w;
      int pct;
      if (sq0.size() == 0) begin
        int len;
        len = $urandom_range(1, 4);
        for (int j = 0; j < len; j++) sq0.push_back({(j == len - 1), 8'($urandom)});
      end
      if (sq1.size() == 0) begin
        int len;
        len = $urandom_range(1, 4);
        for (int j = 0; j < len; j++) sq1.push_back({(j == len - 1), 8'($urandom)});
      end
      pct = ((i / 100) % 2 == 1) ? 2 : 8;
      w[0] = ($urandom_range(0, 9) < pct);
      w[1] = ($urandom_range(0, 9) < pct);
      run_cycle(w, ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  // hard stop if anything stalls
  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end
endmodule
